// File: rtl/trace_pkg.sv
// Shared types and constants for the writeback/store trace capture block.
package trace_pkg;

  // Default field widths used by the packed entry layout below.
  localparam int unsigned TS_W_DEF       = 16;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned DM_ADDRESS_DEF = 9;

  // Saturation ceiling for the dropped-event counter.
  localparam logic [7:0] DROP_MAX = 8'hFF;

  typedef enum logic {
    EV_REG = 1'b0,
    EV_MEM = 1'b1
  } trace_type_e;

  typedef struct packed {
    trace_type_e                typ;
    logic [TS_W_DEF-1:0]        ts;
    logic [DM_ADDRESS_DEF-1:0]  idx;
    logic [DATA_W_DEF-1:0]      data;
  } trace_entry_t;

endpackage

// File: rtl/wb_trace_capture_if.sv
// Valid/ready stream carrying captured trace entries to the consumer.
interface wb_trace_capture_if #(
  parameter int unsigned TS_W       = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DM_ADDRESS = 9
);

  logic                  out_valid;
  logic                  out_ready;
  logic                  out_type;
  logic [TS_W-1:0]       out_ts;
  logic [DM_ADDRESS-1:0] out_idx;
  logic [DATA_W-1:0]     out_data;

  modport master (
    output out_valid, out_type, out_ts, out_idx, out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_type, out_ts, out_idx, out_data,
    output out_ready
  );

endinterface

// File: rtl/trace_fifo.sv
// Dual-push, single-pop, first-word-fall-through FIFO with occupancy count.
// push_n selects how many of din0/din1 are written this cycle (din0 first).
module trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 58
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [1:0]             push_n,
  input  logic [W-1:0]           din0,
  input  logic [W-1:0]           din1,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] wptr_next;
  logic [AW-1:0] rptr;

  assign wptr_next = wptr + AW'(1);

  // Pointer and occupancy bookkeeping; clear flushes without touching storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(push_n);
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      count <= count + CW'(push_n) - CW'(pop);
    end
  end

  // Entry storage; the second push lands in the slot after the first.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (push_n != 2'd0) begin
        mem[wptr] <= din0;
      end
      if (push_n == 2'd2) begin
        mem[wptr_next] <= din1;
      end
    end
  end

  // Head is forced to zero while empty so outputs are clean after reset.
  assign dout = (count != '0) ? mem[rptr] : '0;

endmodule

// File: rtl/wb_trace_capture.sv
// Trace capture: qualifies writeback and store events from the core,
// timestamps them, queues them for a valid/ready consumer and keeps
// drop statistics when the queue cannot take them.
module wb_trace_capture
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned TS_W       = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DM_ADDRESS = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   clear,
  input  logic                   reg_write_sig,
  input  logic [4:0]             reg_num,
  input  logic [DATA_W-1:0]      reg_data,
  input  logic                   wr,
  input  logic [DM_ADDRESS-1:0]  addr,
  input  logic [DATA_W-1:0]      wr_data,
  wb_trace_capture_if.master     trace,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned W  = 1 + TS_W + DM_ADDRESS + DATA_W;

  logic [TS_W-1:0] ts;
  logic            reg_ev;
  logic            mem_ev;
  logic            pop;
  logic [1:0]      need;
  logic [1:0]      grant;
  logic [1:0]      drops;
  logic [CW:0]     free;
  logic [W-1:0]    reg_entry;
  logic [W-1:0]    mem_entry;
  logic [W-1:0]    din0;
  logic [W-1:0]    head;
  logic [8:0]      drop_sum;

  // Event qualification and space arbitration; the writeback is older
  // than the store, so it takes the first slot and the store is the one
  // dropped when only one slot remains.
  always_comb begin
    reg_ev    = enable & reg_write_sig & (reg_num != 5'd0);
    mem_ev    = enable & wr;
    pop       = trace.out_valid & trace.out_ready;
    need      = {1'b0, reg_ev} + {1'b0, mem_ev};
    free      = (CW+1)'(DEPTH) - {1'b0, count} + {{CW{1'b0}}, pop};
    grant     = (free >= {{(CW-1){1'b0}}, need}) ? need : free[1:0];
    drops     = need - grant;
    reg_entry = {EV_REG, ts, DM_ADDRESS'(reg_num), reg_data};
    mem_entry = {EV_MEM, ts, addr, wr_data};
    din0      = reg_ev ? reg_entry : mem_entry;
    drop_sum  = {1'b0, drop_cnt} + {7'b0, drops};
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .push_n (grant),
    .din0   (din0),
    .din1   (mem_entry),
    .pop    (pop),
    .dout   (head),
    .count  (count)
  );

  // Free-running timestamp, independent of enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts <= '0;
    end else if (clear) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_W'(1);
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drops != 2'd0) begin
      overflow <= 1'b1;
      drop_cnt <= drop_sum[8] ? DROP_MAX : drop_sum[7:0];
    end
  end

  // Stream outputs straight from the FIFO head.
  always_comb begin
    trace.out_valid = (count != '0);
    {trace.out_type, trace.out_ts, trace.out_idx, trace.out_data} = head;
  end

endmodule

// File: tb/tb_wb_trace_capture.sv
// Self-checking bench for wb_trace_capture with a scoreboard queue.
module tb_wb_trace_capture;
  import trace_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear;
  logic        reg_write_sig;
  logic [4:0]  reg_num;
  logic [31:0] reg_data;
  logic        wr;
  logic [8:0]  addr;
  logic [31:0] wr_data;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  wb_trace_capture_if #(.TS_W(16), .DATA_W(32), .DM_ADDRESS(9)) bus ();

  wb_trace_capture #(
    .DEPTH      (DEPTH),
    .TS_W       (16),
    .DATA_W     (32),
    .DM_ADDRESS (9)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .clear         (clear),
    .reg_write_sig (reg_write_sig),
    .reg_num       (reg_num),
    .reg_data      (reg_data),
    .wr            (wr),
    .addr          (addr),
    .wr_data       (wr_data),
    .trace         (bus),
    .count         (count),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  trace_entry_t q[$];
  int           exp_count = 0;
  int           exp_drop  = 0;
  logic         exp_ovf   = 1'b0;
  logic [15:0]  ts_m;

  // Reference timestamp: counts every edge, zeroed by reset and clear.
  always @(posedge clk or negedge reset) begin
    if (!reset) ts_m <= '0;
    else if (clear) ts_m <= '0;
    else ts_m <= ts_m + 16'd1;
  end

  function automatic trace_entry_t observed();
    trace_entry_t o;
    o = {bus.out_type, bus.out_ts, bus.out_idx, bus.out_data};
    return o;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_count = 0;
    exp_drop  = 0;
    exp_ovf   = 1'b0;
  endtask

  task automatic note_drop();
    exp_ovf = 1'b1;
    if (exp_drop < 255) exp_drop++;
  endtask

  // Drive one cycle of stimulus, update the reference model, advance one edge.
  task automatic drive(input logic r, input logic [4:0] n, input logic [31:0] d,
                       input logic m, input logic [8:0] a, input logic [31:0] md,
                       input logic p, input logic c);
    trace_entry_t e;
    int free;
    logic rq, mq;
    reg_write_sig = r; reg_num = n; reg_data = d;
    wr = m; addr = a; wr_data = md;
    bus.out_ready = p; clear = c;
    rq = enable && r && (n != 5'd0);
    mq = enable && m;
    if (c) begin
      model_reset();
    end else begin
      if (p && exp_count > 0) begin
        e = q.pop_front();
        exp_count--;
      end
      free = DEPTH - exp_count;
      if (rq) begin
        if (free > 0) begin
          e.typ = EV_REG; e.ts = ts_m; e.idx = {4'b0, n}; e.data = d;
          q.push_back(e); exp_count++; free--;
        end else note_drop();
      end
      if (mq) begin
        if (free > 0) begin
          e.typ = EV_MEM; e.ts = ts_m; e.idx = a; e.data = md;
          q.push_back(e); exp_count++; free--;
        end else note_drop();
      end
    end
    @(posedge clk);
    #1;
    reg_write_sig = 1'b0; wr = 1'b0; clear = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    trace_entry_t o;
    reset = 1'b0; enable = 1'b0; clear = 1'b0;
    reg_write_sig = 1'b0; reg_num = '0; reg_data = '0;
    wr = 1'b0; addr = '0; wr_data = '0; bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    o = observed();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
    total++; if (o !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", o); end
    reset = 1'b1;
  endtask

  task automatic test_single();
    trace_entry_t o;
    enable = 1'b1;
    for (int g = 0; g < 100 && ts_m != 16'd3; g++) idle();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0);
    o = observed();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", bus.out_valid); end
    total++; if (o !== {EV_REG, 16'd3, 9'd5, 32'hDEADBEEF})
      begin bad++; $display("FAIL single_entry got=%h want=%h", o, {EV_REG, 16'd3, 9'd5, 32'hDEADBEEF}); end
    total++; if (count !== 5'd1) begin bad++; $display("FAIL single_count got=%0d want=1", count); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL single_pop_count got=%0d want=0", count); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_filter();
    drive(1'b1, 5'd0, 32'h1234, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL x0_count got=%0d want=0", count); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL x0_drop got=%0d want=0", drop_cnt); end
    enable = 1'b0;
    drive(1'b1, 5'd7, 32'h5678, 1'b1, 9'h010, 32'h9, 1'b0, 1'b0);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL disabled_count got=%0d want=0", count); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL disabled_drop got=%0d want=0", drop_cnt); end
    enable = 1'b1;
  endtask

  task automatic test_simultaneous();
    trace_entry_t o;
    trace_entry_t e;
    logic [15:0] ts_ev;
    ts_ev = ts_m;
    drive(1'b1, 5'd2, 32'h11, 1'b1, 9'h040, 32'h22, 1'b0, 1'b0);
    total++; if (count !== 5'd2) begin bad++; $display("FAIL simul_count2 got=%0d want=2", count); end
    o = observed();
    e = '{typ: EV_REG, ts: ts_ev, idx: 9'd2, data: 32'h11};
    total++; if (o !== e) begin bad++; $display("FAIL simul_first got=%h want=%h", o, e); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0);
    total++; if (count !== 5'd1) begin bad++; $display("FAIL simul_count1 got=%0d want=1", count); end
    o = observed();
    e = '{typ: EV_MEM, ts: ts_ev, idx: 9'h040, data: 32'h22};
    total++; if (o !== e) begin bad++; $display("FAIL simul_second got=%h want=%h", o, e); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL simul_count0 got=%0d want=0", count); end
  endtask

  task automatic test_full();
    trace_entry_t o;
    for (int i = 0; i < 15; i++) begin
      if (i % 2 == 0) drive(1'b1, 5'(1 + i), $urandom, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0);
      else            drive(1'b0, 5'd0, 32'd0, 1'b1, 9'(i * 3), $urandom, 1'b0, 1'b0);
    end
    total++; if (count !== 5'd15) begin bad++; $display("FAIL full_count15 got=%0d want=15", count); end
    drive(1'b1, 5'd10, 32'hA0, 1'b1, 9'h1F0, 32'hB0, 1'b0, 1'b0);
    total++; if (count !== 5'd16) begin bad++; $display("FAIL full_count16 got=%0d want=16", count); end
    total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL full_drop1 got=%0d want=1", drop_cnt); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_overflow got=%b want=1", overflow); end
    drive(1'b1, 5'd11, 32'hA1, 1'b1, 9'h1F1, 32'hB1, 1'b0, 1'b0);
    total++; if (drop_cnt !== 8'd3) begin bad++; $display("FAIL full_drop3 got=%0d want=3", drop_cnt); end
    // Pop and push together at full: one slot is freed, one push succeeds.
    o = observed();
    total++; if (o !== q[0]) begin bad++; $display("FAIL popfull_head got=%h want=%h", o, q[0]); end
    drive(1'b1, 5'd9, 32'hCAFE0001, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0);
    total++; if (count !== 5'd16) begin bad++; $display("FAIL popfull_count got=%0d want=16", count); end
    total++; if (drop_cnt !== 8'd3) begin bad++; $display("FAIL popfull_drop got=%0d want=3", drop_cnt); end
    for (int i = 0; i < 300; i++)
      drive(1'b1, 5'd12, 32'hA2, 1'b1, 9'h1F2, 32'hB2, 1'b0, 1'b0);
    total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL full_saturate got=%0d want=255", drop_cnt); end
    total++; if (drop_cnt !== 8'(exp_drop)) begin bad++; $display("FAIL full_drop_model got=%0d want=%0d", drop_cnt, exp_drop); end
  endtask

  task automatic test_drain();
    trace_entry_t o;
    logic [31:0] last_data;
    last_data = '0;
    for (int i = 0; i < 40 && exp_count > 0; i++) begin
      o = observed();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL drain_valid got=%b want=1", bus.out_valid); end
      total++; if (o !== q[0]) begin bad++; $display("FAIL drain_entry got=%h want=%h", o, q[0]); end
      last_data = bus.out_data;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0);
    end
    total++; if (last_data !== 32'hCAFE0001) begin bad++; $display("FAIL drain_last got=%h want=cafe0001", last_data); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL drain_count got=%0d want=0", count); end
  endtask

  task automatic test_clear();
    trace_entry_t o;
    for (int i = 0; i < 8; i++) drive(1'b1, 5'(3 + i), 32'(i), 1'b0, 9'd0, 32'd0, 1'b0, 1'b0);
    total++; if (count !== 5'd8) begin bad++; $display("FAIL clear_pre_count got=%0d want=8", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL clear_pre_ovf got=%b want=1", overflow); end
    drive(1'b1, 5'd3, 32'h55, 1'b1, 9'h003, 32'h66, 1'b1, 1'b1);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL clear_count got=%0d want=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clear_ovf got=%b want=0", overflow); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL clear_drop got=%0d want=0", drop_cnt); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL clear_valid got=%b want=0", bus.out_valid); end
    drive(1'b1, 5'd4, 32'h77, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0);
    o = observed();
    total++; if (bus.out_ts !== 16'd0) begin bad++; $display("FAIL clear_ts got=%0d want=0", bus.out_ts); end
    total++; if (o !== q[0]) begin bad++; $display("FAIL clear_entry got=%h want=%h", o, q[0]); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    trace_entry_t o;
    logic p;
    for (int i = 0; i < 40; i++) begin
      p = (exp_count > 0);
      if (p) begin
        o = observed();
        total++; if (o !== q[0]) begin bad++; $display("FAIL b2b_entry got=%h want=%h", o, q[0]); end
      end
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), $urandom, p, 1'b0);
    end
    total++; if (count !== 5'(exp_count)) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", count, exp_count); end
    total++; if (drop_cnt !== 8'(exp_drop)) begin bad++; $display("FAIL b2b_drop got=%0d want=%0d", drop_cnt, exp_drop); end
    for (int i = 0; i < 40 && exp_count > 0; i++) begin
      o = observed();
      total++; if (o !== q[0]) begin bad++; $display("FAIL b2b_drain got=%h want=%h", o, q[0]); end
      drive(1'b0, 5'd0, 32'd0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    trace_entry_t o;
    for (int i = 0; i < 3; i++) drive(1'b1, 5'd20, 32'(i), 1'b1, 9'd7, 32'(i), 1'b0, 1'b0);
    total++; if (count !== 5'd6) begin bad++; $display("FAIL areset_pre_count got=%0d want=6", count); end
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b want=0", bus.out_valid); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL areset_count got=%0d want=0", count); end
    reset = 1'b1;
    drive(1'b1, 5'd21, 32'hF00D, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0);
    o = observed();
    total++; if (count !== 5'd1) begin bad++; $display("FAIL areset_post_count got=%0d want=1", count); end
    total++; if (o !== {EV_REG, 16'd0, 9'd21, 32'hF00D})
      begin bad++; $display("FAIL areset_post_entry got=%h want=%h", o, {EV_REG, 16'd0, 9'd21, 32'hF00D}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_filter();
    test_simultaneous();
    test_full();
    test_drain();
    test_clear();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_trace_capture.md
Name: wb_trace_capture

Overview:
- Consumer for the core's debug trace outputs: register writeback (reg_write_sig, reg_num, reg_data) and data-memory store (wr, addr, wr_data).
- Timestamps each qualified event and buffers it in a FIFO.
- A host or testbench drains the FIFO through a valid/ready interface.
- Sits beside the core in the top level and testbench; it never feeds back into the datapath.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 4.
- TS_W, 16, timestamp counter width.
- DATA_W, 32, data width of register and store values.
- DM_ADDRESS, 9, data-memory address width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable; events are ignored while low.
- clear  in  1  synchronous flush of FIFO, timestamp and statistics.
- reg_write_sig  in  1  writeback strobe from the core.
- reg_num  in  5  destination register of the writeback.
- reg_data  in  DATA_W  writeback value.
- wr  in  1  store strobe from the core's MEM stage.
- addr  in  DM_ADDRESS  store address.
- wr_data  in  DATA_W  store data.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head.
- out_type  out  1  0 = register writeback, 1 = memory store.
- out_ts  out  TS_W  timestamp of the event.
- out_idx  out  DM_ADDRESS  rd (zero-extended) for type 0; addr for type 1.
- out_data  out  DATA_W  reg_data or wr_data.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when any event is dropped.
- drop_cnt  out  8  saturating count of dropped events.

Behaviour:
- Reset (reset low, asynchronous):
  - FIFO pointers, count, timestamp, overflow and drop_cnt are cleared to 0.
  - out_valid=0; out_type, out_ts, out_idx and out_data are 0.
  - Effect is immediate, including mid-stream; all buffered entries are lost.
- Timestamp:
  - Free-running TS_W counter, increments every cycle and wraps from 2^TS_W-1 to 0.
  - It runs regardless of enable.
  - An event captures the counter value of the cycle in which it is sampled.
- Event qualification, sampled each cycle:
  - reg_ev = enable & reg_write_sig & (reg_num != 0). Writes to x0 are never captured.
  - mem_ev = enable & wr.
- Ordering: when both events occur in the same cycle, the reg_ev entry is pushed first (older instruction, WB stage), then mem_ev. Both carry the same timestamp.
- Pop: pop = out_valid & out_ready. The head advances on the next edge.
- Space accounting: free = DEPTH - count + pop.
  - Need 2, free >= 2: push both.
  - Need 2, free == 1: push reg_ev, drop mem_ev.
  - Need 1, free >= 1: push it.
  - free == 0: drop all requested events.
- Drops:
  - drop_cnt increments by the number dropped (1 or 2) and saturates at 255.
  - overflow is set and stays set until clear or reset.
- Latency and outputs:
  - An event sampled at edge N is visible on out_valid/out_* after edge N (first-word fall-through).
  - out_valid = (count != 0).
  - out_* are stable while out_valid=1 and out_ready=0.
  - out_* are don't-care when out_valid=0; the bench must not check them.
- count is updated each edge by +pushes - pop, range 0..DEPTH.
- Simultaneous push and pop at full: the pop frees one slot, so one push succeeds.
- clear:
  - Takes priority over push and pop in the same cycle.
  - Empties the FIFO and zeroes the timestamp, overflow and drop_cnt.
  - Events in the clear cycle are discarded and not counted as drops.
- Pointers wrap modulo DEPTH; full and empty are distinguished by count.

Decomposition:
- Package trace_pkg holds:
  - typedef enum logic {EV_REG=0, EV_MEM=1} trace_type_e.
  - typedef struct packed {trace_type_e typ; logic [TS_W-1:0] ts; logic [DM_ADDRESS-1:0] idx; logic [DATA_W-1:0] data;} trace_entry_t, with package-level default widths.
  - Localparam DROP_MAX = 8'hFF.
- Sub-module trace_fifo: dual-push, single-pop, first-word-fall-through, with count output.
- Qualification, timestamp and drop statistics live in wb_trace_capture.

Test Plan:
- Single writeback: enable=1, reg_write_sig=1, reg_num=5, reg_data=32'hDEADBEEF at ts=3. Next cycle: out_valid=1, type 0, idx 5, data DEADBEEF, ts 3, count 1. Pop with out_ready=1, then count 0.
- x0 filter and enable: reg_num=0 with strobe, then reg_num=7 with enable=0. Both cycles leave count=0 and drop_cnt=0.
- Simultaneous events: reg (rd=2, 32'h11) and store (addr=9'h040, 32'h22) in one cycle. Pops return reg first, then mem, with equal ts; count goes 2, then 1, then 0.
- Full and backpressure:
  - With out_ready=0, push 15 single events, then one dual event. The reg entry is kept (count=16), the mem entry is dropped: drop_cnt=1, overflow=1.
  - A further dual event gives drop_cnt=3.
  - Then 300 more dual events: drop_cnt saturates at 255.
- Pop plus push at full: count=16, out_ready=1 and one reg event in the same cycle. count stays 16, no drop, and the new entry appears last in pop order.
- Clear and reset:
  - clear with count=8, overflow=1 and a simultaneous event: next cycle count=0, overflow=0, drop_cnt=0, ts=0.
  - Assert reset low between edges: out_valid and count go to 0 immediately.
